// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported memory with
// combinational read data and a configurable number of access wait states.
module mem_arbiter #(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        p0_req_i,
  input  logic        p0_we_i,
  input  logic [1:0]  p0_size_i,
  input  logic [7:0]  p0_addr_i,
  input  logic [31:0] p0_wdata_i,
  output logic        p0_ack_o,
  output logic [31:0] p0_rdata_o,
  input  logic        p1_req_i,
  input  logic        p1_we_i,
  input  logic [1:0]  p1_size_i,
  input  logic [7:0]  p1_addr_i,
  input  logic [31:0] p1_wdata_i,
  output logic        p1_ack_o,
  output logic [31:0] p1_rdata_o,
  output logic [7:0]  mem_address_o,
  output logic [31:0] mem_write_data_o,
  output logic [1:0]  mem_read_o,
  output logic [1:0]  mem_write_o,
  input  logic [31:0] mem_read_data_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        winner_q, winner_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] p0_rdata_q, p0_rdata_d;
  logic [31:0] p1_rdata_q, p1_rdata_d;
  logic        any_req;
  logic        grant_p1;
  logic [31:0] rd_value;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      winner_q   <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      winner_q   <= winner_d;
      we_q       <= we_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  // last_q set means p1 was granted last, so p0 takes the next tie.
  always_comb begin
    any_req    = p0_req_i | p1_req_i;
    grant_p1   = p1_req_i & (~p0_req_i | ~last_q);
    rd_value   = (size_q == 2'b00) ? 32'h0 : mem_read_data_i;
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    winner_d   = winner_q;
    we_d       = we_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d  = ACCESS;
          winner_d = grant_p1;
          last_d   = grant_p1;
          cnt_d    = WAIT_LOAD;
          we_d     = grant_p1 ? p1_we_i    : p0_we_i;
          size_d   = grant_p1 ? p1_size_i  : p0_size_i;
          addr_d   = grant_p1 ? p1_addr_i  : p0_addr_i;
          wdata_d  = grant_p1 ? p1_wdata_i : p0_wdata_i;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          if (!we_q) begin
            if (winner_q) p1_rdata_d = rd_value;
            else          p0_rdata_d = rd_value;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_address_o    = addr_q;
    mem_write_data_o = wdata_q;
    mem_read_o       = 2'b00;
    mem_write_o      = 2'b00;
    p0_ack_o         = 1'b0;
    p1_ack_o         = 1'b0;
    p0_rdata_o       = p0_rdata_q;
    p1_rdata_o       = p1_rdata_q;
    busy_o           = (state_q != IDLE);
    if (state_q == ACCESS) begin
      if (we_q) mem_write_o = size_q;
      else      mem_read_o  = size_q;
    end
    if (state_q == RESP) begin
      p0_ack_o = ~winner_q;
      p1_ack_o = winner_q;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (0 and 3 wait states) with a word memory,
// checked against a transaction-level model of memory, rdata and round-robin grants.
module tb_mem_arbiter;

  logic        clk;
  logic        rst      [2];
  logic        req      [2][2];
  logic        we       [2][2];
  logic [1:0]  size     [2][2];
  logic [7:0]  addr     [2][2];
  logic [31:0] wdata    [2][2];
  logic        ack      [2][2];
  logic [31:0] rdata    [2][2];
  logic [7:0]  mem_addr [2];
  logic [31:0] mem_wd   [2];
  logic [31:0] mem_rd   [2];
  logic [1:0]  mem_rd_sz[2];
  logic [1:0]  mem_wr_sz[2];
  logic        busy     [2];
  logic        mem_clr;
  logic [31:0] mem      [2][256];

  logic [31:0] shadow   [2][256];
  logic [31:0] exp_rdata[2][2];
  int          last_grant[2];
  int          total = 0;
  int          bad   = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.WAIT_STATES(g == 0 ? 0 : 3)) u_dut (
      .clk_i           (clk),
      .rst_i           (rst[g]),
      .p0_req_i        (req[g][0]),
      .p0_we_i         (we[g][0]),
      .p0_size_i       (size[g][0]),
      .p0_addr_i       (addr[g][0]),
      .p0_wdata_i      (wdata[g][0]),
      .p0_ack_o        (ack[g][0]),
      .p0_rdata_o      (rdata[g][0]),
      .p1_req_i        (req[g][1]),
      .p1_we_i         (we[g][1]),
      .p1_size_i       (size[g][1]),
      .p1_addr_i       (addr[g][1]),
      .p1_wdata_i      (wdata[g][1]),
      .p1_ack_o        (ack[g][1]),
      .p1_rdata_o      (rdata[g][1]),
      .mem_address_o   (mem_addr[g]),
      .mem_write_data_o(mem_wd[g]),
      .mem_read_o      (mem_rd_sz[g]),
      .mem_write_o     (mem_wr_sz[g]),
      .mem_read_data_i (mem_rd[g]),
      .busy_o          (busy[g])
    );
    assign mem_rd[g] = mem[g][mem_addr[g]];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_clr) begin
        for (int j = 0; j < 256; j++) mem[i][j] <= 32'h0;
      end else if (mem_wr_sz[i] != 2'b00) begin
        mem[i][mem_addr[i]] <= mem_wd[i];
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Transaction-level model: a completed transfer updates memory, rdata and last grant.
  task automatic modelApply(input int d, input int p, input logic w, input logic [1:0] s,
                            input logic [7:0] a, input logic [31:0] x);
    last_grant[d] = p;
    if (w) begin
      if (s != 2'b00) shadow[d][a] = x;
    end else begin
      exp_rdata[d][p] = (s == 2'b00) ? 32'h0 : shadow[d][a];
    end
  endtask

  task automatic checkRdata(input int d);
    checkOutput("rdata_p0", rdata[d][0], exp_rdata[d][0]);
    checkOutput("rdata_p1", rdata[d][1], exp_rdata[d][1]);
  endtask

  task automatic checkReset(input int d);
    checkOutput("rst_ack_p0", 32'(ack[d][0]), 32'h0);
    checkOutput("rst_ack_p1", 32'(ack[d][1]), 32'h0);
    checkOutput("rst_rdata_p0", rdata[d][0], 32'h0);
    checkOutput("rst_rdata_p1", rdata[d][1], 32'h0);
    checkOutput("rst_mem_read", 32'(mem_rd_sz[d]), 32'h0);
    checkOutput("rst_mem_write", 32'(mem_wr_sz[d]), 32'h0);
    checkOutput("rst_mem_addr", 32'(mem_addr[d]), 32'h0);
    checkOutput("rst_mem_wdata", mem_wd[d], 32'h0);
    checkOutput("rst_busy", 32'(busy[d]), 32'h0);
  endtask

  task automatic applyStimulus(input int d, input int p, input logic w, input logic [1:0] s,
                               input logic [7:0] a, input logic [31:0] x, input bit drop);
    int ws = (d == 0) ? 0 : 3;
    int cyc = 0;
    int strobes = 0;
    int bad_strobes = 0;
    int other_ack = 0;
    int busy_seen = 0;
    bit seen = 0;
    @(negedge clk);
    req[d][p] = 1'b1; we[d][p] = w; size[d][p] = s; addr[d][p] = a; wdata[d][p] = x;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (drop) req[d][p] = 1'b0;
      if (mem_wr_sz[d] != 2'b00 || mem_rd_sz[d] != 2'b00) begin
        if ((w ? mem_wr_sz[d] : mem_rd_sz[d]) == s && (w ? mem_rd_sz[d] : mem_wr_sz[d]) == 2'b00 &&
            mem_addr[d] == a && (!w || mem_wd[d] == x))
          strobes++;
        else
          bad_strobes++;
      end
      if (ack[d][1-p]) other_ack++;
      if (busy[d]) busy_seen++;
      if (ack[d][p]) seen = 1;
    end
    req[d][p] = 1'b0;
    checkOutput("ack_latency", cyc, 2 + ws);
    checkOutput("strobe_cycles", strobes, (w && s != 2'b00) || (!w && s != 2'b00) ? ws + 1 : 0);
    checkOutput("strobe_wrong", bad_strobes, 0);
    checkOutput("other_port_ack", other_ack, 0);
    checkOutput("busy_cycles", busy_seen, 2 + ws);
    modelApply(d, p, w, s, a, x);
    checkRdata(d);
    @(negedge clk);
    checkOutput("ack_one_cycle", 32'(ack[d][p]), 32'h0);
    checkOutput("busy_idle", 32'(busy[d]), 32'h0);
  endtask

  task automatic applyStimulusPair(input int d,
                                   input logic w0, input logic [1:0] s0, input logic [7:0] a0, input logic [31:0] x0,
                                   input logic w1, input logic [1:0] s1, input logic [7:0] a1, input logic [31:0] x1);
    int ws = (d == 0) ? 0 : 3;
    int cyc = 0;
    int overlap = 0;
    int first = -1;
    int second;
    int exp_first;
    bit done = 0;
    logic        tw[2];
    logic [1:0]  ts[2];
    logic [7:0]  ta[2];
    logic [31:0] tx[2];
    tw[0] = w0; ts[0] = s0; ta[0] = a0; tx[0] = x0;
    tw[1] = w1; ts[1] = s1; ta[1] = a1; tx[1] = x1;
    exp_first = (last_grant[d] == 1) ? 0 : 1;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      req[d][p] = 1'b1; we[d][p] = tw[p]; size[d][p] = ts[p]; addr[d][p] = ta[p]; wdata[d][p] = tx[p];
    end
    while (first < 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (ack[d][0] && ack[d][1]) overlap++;
      if (ack[d][0]) first = 0;
      else if (ack[d][1]) first = 1;
    end
    if (first < 0) begin
      req[d][0] = 1'b0; req[d][1] = 1'b0;
      checkOutput("pair_timeout", 32'h1, 32'h0);
      return;
    end
    checkOutput("pair_first_port", first, exp_first);
    checkOutput("pair_first_latency", cyc, 2 + ws);
    second = 1 - first;
    req[d][first] = 1'b0;
    modelApply(d, first, tw[first], ts[first], ta[first], tx[first]);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (ack[d][first]) overlap++;
      if (ack[d][second]) done = 1;
    end
    req[d][second] = 1'b0;
    checkOutput("pair_second_latency", cyc, 3 + ws);
    checkOutput("pair_ack_overlap", overlap, 0);
    modelApply(d, second, tw[second], ts[second], ta[second], tx[second]);
    checkRdata(d);
    @(negedge clk);
    checkOutput("pair_busy_idle", 32'(busy[d]), 32'h0);
  endtask

  initial begin
    logic        w0, w1;
    logic [1:0]  s0, s1;
    logic [7:0]  a0, a1;
    logic [31:0] x0, x1;
    int          p;
    mem_clr = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      last_grant[d] = 1;
      for (int q = 0; q < 2; q++) begin
        req[d][q] = 1'b0; we[d][q] = 1'b0; size[d][q] = 2'b00;
        addr[d][q] = 8'h0; wdata[d][q] = 32'h0; exp_rdata[d][q] = 32'h0;
      end
      for (int j = 0; j < 256; j++) shadow[d][j] = 32'h0;
    end
    repeat (3) @(negedge clk);
    checkReset(0);
    checkReset(1);
    rst[0] = 1'b0; rst[1] = 1'b0; mem_clr = 1'b0;

    $display("[TB] simultaneous requests after reset");
    applyStimulusPair(1, 1'b1, 2'b11, 8'h01, 32'h1111_0000, 1'b1, 2'b11, 8'h02, 32'h2222_0000);
    applyStimulusPair(1, 1'b0, 2'b11, 8'h02, 32'h0, 1'b0, 2'b11, 8'h01, 32'h0);
    checkOutput("rr_p0_read", rdata[1][0], 32'h2222_0000);
    checkOutput("rr_p1_read", rdata[1][1], 32'h1111_0000);

    $display("[TB] zero wait-state write then read");
    applyStimulus(0, 0, 1'b1, 2'b11, 8'h10, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(0, 0, 1'b0, 2'b11, 8'h10, 32'h0, 1'b0);
    checkOutput("ws0_read_data", rdata[0][0], 32'hDEAD_BEEF);

    $display("[TB] three wait-state byte read on p1");
    applyStimulus(1, 0, 1'b1, 2'b11, 8'h05, 32'hFFFF_FF80, 1'b0);
    applyStimulus(1, 1, 1'b0, 2'b01, 8'h05, 32'h0, 1'b0);
    checkOutput("ws3_byte_read", rdata[1][1], 32'hFFFF_FF80);

    $display("[TB] size none request");
    applyStimulus(1, 1, 1'b0, 2'b00, 8'h05, 32'h0, 1'b0);
    checkOutput("size_none_rdata", rdata[1][1], 32'h0);
    applyStimulus(0, 1, 1'b1, 2'b00, 8'h10, 32'h1234_5678, 1'b0);
    applyStimulus(0, 1, 1'b0, 2'b11, 8'h10, 32'h0, 1'b1);

    $display("[TB] reset during access");
    @(negedge clk);
    req[1][0] = 1'b1; we[1][0] = 1'b0; size[1][0] = 2'b11; addr[1][0] = 8'h05;
    @(negedge clk);
    checkOutput("abort_in_access", 32'(mem_rd_sz[1]), 32'h3);
    rst[1] = 1'b1; req[1][0] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b0;
    checkReset(1);
    last_grant[1] = 1;
    exp_rdata[1][0] = 32'h0; exp_rdata[1][1] = 32'h0;
    applyStimulus(1, 0, 1'b0, 2'b11, 8'h05, 32'h0, 1'b0);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 30; k++) begin
      for (int d = 0; d < 2; d++) begin
        w0 = 1'($urandom_range(0, 1)); s0 = 2'($urandom_range(0, 3));
        a0 = 8'($urandom_range(0, 15)); x0 = $urandom;
        w1 = 1'($urandom_range(0, 1)); s1 = 2'($urandom_range(0, 3));
        a1 = 8'($urandom_range(0, 15)); x1 = $urandom;
        p  = int'($urandom_range(0, 1));
        if ($urandom_range(0, 2) == 0)
          applyStimulusPair(d, w0, s0, a0, x0, w1, s1, a1, x1);
        else
          applyStimulus(d, p, w0, s0, a0, x0, 1'($urandom_range(0, 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_STATES, default 0, extra ACCESS cycles per transfer (legal 0..15).
REQ-002 clk_i  input  1  single clock; all state changes on posedge.
REQ-003 rst_i  input  1  synchronous reset, active-high.
REQ-004 p0_req_i  input  1  pipeline-port request; held high until p0_ack_o.
REQ-005 p0_we_i  input  1  1 = write, 0 = read.
REQ-006 p0_size_i  input  2  access size: 2'b00 none, 2'b01 byte, 2'b10 halfword, 2'b11 word.
REQ-007 p0_addr_i  input  8  word address.
REQ-008 p0_wdata_i  input  32  write data.
REQ-009 p0_ack_o  output  1  one-cycle completion pulse.
REQ-010 p0_rdata_o  output  32  read data, valid with p0_ack_o and held afterwards.
REQ-011 p1_req_i, p1_we_i, p1_size_i, p1_addr_i, p1_wdata_i, p1_ack_o, p1_rdata_o SHALL mirror p0_* (loader/debug port).
REQ-012 mem_address_o  output  8  memory address.
REQ-013 mem_write_data_o  output  32  memory write data.
REQ-014 mem_read_o  output  2  memory read size; 2'b00 idle.
REQ-015 mem_write_o  output  2  memory write size; 2'b00 idle.
REQ-016 mem_read_data_i  input  32  combinational memory read data.
REQ-017 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-019 IDLE: no request -> stay; any request -> latch winner's we/size/addr/wdata, record winner, load wait counter with WAIT_STATES, go ACCESS.
REQ-020 Arbitration SHALL be round-robin: sole requester wins; on tie, the port not granted last wins; last_grant updates on every grant.
REQ-021 ACCESS: mem_address_o/mem_write_data_o SHALL drive latched values; mem_write_o = latched size if we else 2'b00; mem_read_o = latched size if ~we else 2'b00.
REQ-022 ACCESS: counter != 0 -> decrement, stay; counter == 0 -> capture mem_read_data_i into winner's rdata register if read, go RESP.
REQ-023 RESP: winner's ack_o high exactly this cycle; mem_read_o = mem_write_o = 2'b00; go IDLE unconditionally.
REQ-024 Outside ACCESS, mem_read_o and mem_write_o SHALL be 2'b00; address/data outputs hold latched values.
REQ-025 Latency: request sampled in IDLE at edge N -> ack high in cycle N+2+WAIT_STATES; one transfer per WAIT_STATES+3 cycles.
REQ-026 Request inputs SHALL be ignored outside IDLE; a requester deasserting mid-transfer does not abort it; ack is still pulsed.
REQ-027 Size 2'b00 request SHALL complete normally with no memory access; read returns rdata = 0.
REQ-028 pX_rdata_o SHALL change only on read completion of port X; writes and the other port leave it unchanged.
REQ-029 Never more than one ack_o high per cycle; ack_o never high outside RESP.

Reset
REQ-030 rst_i high at posedge -> state IDLE, counter 0, last_grant = p1 (p0 wins first tie), both ack_o 0, both rdata_o 0, mem_read_o = mem_write_o = 2'b00, mem_address_o 0, mem_write_data_o 0, busy_o 0.
REQ-031 Reset mid-transfer SHALL abort it with no ack; a write whose ACCESS cycle already elapsed remains committed.

Verification
REQ-032 WAIT_STATES=0, p0 word write addr 0x10 data 0xDEADBEEF, then p0 word read 0x10 -> mem_write_o=2'b11 one cycle; read ack 2 cycles after request, p0_rdata_o=0xDEADBEEF.
REQ-033 Both ports request at once after reset, held -> grant order p0, p1, p0, p1; acks alternate, never coincide.
REQ-034 WAIT_STATES=3, p1 byte read addr 0x05 (mem returns 0xFFFFFF80) -> ACCESS held 4 cycles with mem_read_o=2'b01, p1_ack_o at cycle 5, p1_rdata_o=0xFFFFFF80, p0_rdata_o unchanged.
REQ-035 rst_i asserted during ACCESS of p0 read -> no ack, next cycle all outputs at REQ-030 values, new request served normally.
REQ-036 p1 request with size 2'b00 -> no memory strobes, p1_ack_o after 2 cycles, p1_rdata_o=0.
